ice_cream_dispenser_ctrl: RTL and testbench

Sequences the scoop actuator for the ice-cream vending machine. Accepts ball-count orders (1 or 2 balls) from the coin-handling FSM and queues them in a small FIFO. Drives the scoop actuator one ball at a time with a go/done handshake, tracks remaining tub stock and flags actuator timeouts. Sits between the vending FSM's `ice_cream_balls` output and the physical dispenser.

---
 rtl/ice_cream_pkg.sv | 20 ++
 rtl/ice_cream_dispenser_ctrl_if.sv | 25 ++
 rtl/order_fifo.sv | 79 +++++++
 rtl/ice_cream_dispenser_ctrl.sv | 153 +++++++++++++++
 tb/tb_ice_cream_dispenser_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ice_cream_pkg.sv
// Shared types and constants for the ice-cream scoop sequencer.
//   state_e            : sequencer FSM states
//   BALLS_1 / BALLS_2  : the only legal order sizes
//   DEFAULT_*          : default stock reload value and actuator timeout
package ice_cream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScoop,
    StGap,
    StFault
  } state_e;

  localparam logic [1:0] BALLS_1 = 2'd1;
  localparam logic [1:0] BALLS_2 = 2'd2;

  localparam int unsigned DEFAULT_STOCK_INIT = 20;
  localparam int unsigned DEFAULT_TIMEOUT    = 8;

endpackage

// File: rtl/ice_cream_dispenser_ctrl_if.sv
// Order handshake between the coin-handling FSM (master) and the dispenser (slave).
//   req_valid  : order present this cycle
//   req_balls  : ball count of the order
//   req_ready  : dispenser can take an order
//   req_reject : one-cycle pulse, order refused (bad count or not enough stock)
interface ice_cream_dispenser_ctrl_if;
  logic       req_valid;
  logic [1:0] req_balls;
  logic       req_ready;
  logic       req_reject;

  modport master (
    output req_valid,
    output req_balls,
    input  req_ready,
    input  req_reject
  );

  modport slave (
    input  req_valid,
    input  req_balls,
    output req_ready,
    output req_reject
  );
endinterface

// File: rtl/order_fifo.sv
// Synchronous order FIFO holding 2-bit ball counts.
//   clk, reset : clock, async active-high reset
//   push_i/data_i, pop_i/data_o : write / read (data_o is the current head)
//   full_o, empty_o, level_o    : occupancy status
//   sum_o      : running sum of all queued ball counts
module order_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SUM_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [1:0]               data_i,
  input  logic                     pop_i,
  output logic [1:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [SUM_W-1:0]         sum_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign sum_o   = sum_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sum_d    = sum_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      sum_d           = sum_d + SUM_W'(data_i);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      sum_d    = sum_d - SUM_W'(data_o);
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sum_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sum_q    <= sum_d;
    end
  end

endmodule

// File: rtl/ice_cream_dispenser_ctrl.sv
// Scoop actuator sequencer: queues 1/2-ball orders, drives the scoop one ball at a
// time with a go/done handshake, tracks tub stock and latches actuator timeouts.
//   clk, reset     : clock, async active-high reset
//   req            : order handshake (slave side)
//   scoop_go/done  : actuator handshake
//   refill         : reload stock to STOCK_INIT
//   stock, sold_out, served, busy, fault, queue_level : status
module ice_cream_dispenser_ctrl
  import ice_cream_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STOCK_W    = 5,
  parameter int unsigned STOCK_INIT = DEFAULT_STOCK_INIT,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  ice_cream_dispenser_ctrl_if.slave   req,
  output logic                        scoop_go,
  input  logic                        scoop_done,
  input  logic                        refill,
  output logic [STOCK_W-1:0]          stock,
  output logic                        sold_out,
  output logic                        served,
  output logic                        busy,
  output logic                        fault,
  output logic [$clog2(DEPTH):0]      queue_level
);

  localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;

  state_e             state_q, state_d;
  logic [1:0]         balls_left_q, balls_left_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic               go_q, go_d;
  logic               served_q, served_d;
  logic               fault_q, fault_d;

  logic               fifo_full, fifo_empty, fifo_pop, accept, legal;
  logic [1:0]         fifo_head;
  logic [STOCK_W-1:0] fifo_sum, avail;
  logic [STOCK_W:0]   committed;

  order_fifo #(
    .DEPTH (DEPTH),
    .SUM_W (STOCK_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .data_i  (req.req_balls),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (queue_level),
    .sum_o   (fifo_sum)
  );

  // Balls promised but not yet scooped: queued orders plus the one in flight.
  assign committed = {1'b0, fifo_sum} + (STOCK_W+1)'(balls_left_q);
  assign avail     = ({1'b0, stock_q} > committed) ? (stock_q - committed[STOCK_W-1:0]) : '0;

  assign legal          = (req.req_balls == BALLS_1) || (req.req_balls == BALLS_2);
  assign req.req_ready  = !fifo_full && (avail != '0) && (state_q != StFault);
  assign accept         = req.req_valid && req.req_ready && legal &&
                          (STOCK_W'(req.req_balls) <= avail);
  // Full or faulted means "hold", not "reject".
  assign req.req_reject = req.req_valid && !accept && !fifo_full && (state_q != StFault);

  always_comb begin
    state_d      = state_q;
    balls_left_d = balls_left_q;
    stock_d      = stock_q;
    tmo_d        = tmo_q;
    go_d         = go_q;
    served_d     = 1'b0;
    fault_d      = fault_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // served_q marks the first idle cycle after an order; skipping the pop there
        // guarantees two low scoop_go cycles between back-to-back orders.
        if (!fifo_empty && !served_q) begin
          fifo_pop     = 1'b1;
          balls_left_d = fifo_head;
          go_d         = 1'b1;
          tmo_d        = '0;
          state_d      = StScoop;
        end
      end
      StScoop: begin
        if (scoop_done) begin
          stock_d      = stock_q - 1'b1;
          balls_left_d = balls_left_q - 1'b1;
          go_d         = 1'b0;
          if (balls_left_q == BALLS_1) begin
            served_d = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StGap;
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          go_d    = 1'b0;
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGap: begin
        go_d    = 1'b1;
        tmo_d   = '0;
        state_d = StScoop;
      end
      StFault: begin
        go_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    // Refill overrides any decrement in the same cycle.
    if (refill) stock_d = STOCK_W'(STOCK_INIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      balls_left_q <= '0;
      stock_q      <= STOCK_W'(STOCK_INIT);
      tmo_q        <= '0;
      go_q         <= 1'b0;
      served_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      balls_left_q <= balls_left_d;
      stock_q      <= stock_d;
      tmo_q        <= tmo_d;
      go_q         <= go_d;
      served_q     <= served_d;
      fault_q      <= fault_d;
    end
  end

  assign scoop_go = go_q;
  assign stock    = stock_q;
  assign sold_out = (stock_q == '0);
  assign served   = served_q;
  assign fault    = fault_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_ice_cream_dispenser_ctrl.sv
module tb_ice_cream_dispenser_ctrl;

  logic       clk;
  logic       reset;
  logic       scoop_done;
  logic       refill;
  logic       scoop_go;
  logic [4:0] stock;
  logic       sold_out, served, busy, fault;
  logic [2:0] queue_level;

  int tests_run;
  int tests_failed;

  ice_cream_dispenser_ctrl_if req_if ();

  ice_cream_dispenser_ctrl #(
    .DEPTH      (4),
    .STOCK_W    (5),
    .STOCK_INIT (20),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req_if),
    .scoop_go    (scoop_go),
    .scoop_done  (scoop_done),
    .refill      (refill),
    .stock       (stock),
    .sold_out    (sold_out),
    .served      (served),
    .busy        (busy),
    .fault       (fault),
    .queue_level (queue_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       valid;
    logic [1:0] balls;
    logic       clk_it;
    logic       exp_ready;
    logic       exp_reject;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset             = 1'b1;
    req_if.req_valid  = 1'b0;
    req_if.req_balls  = 2'd0;
    scoop_done        = 1'b0;
    refill            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (scoop_go !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check(name, 32'(scoop_go), 32'd1);
  endtask

  // Push one order and scoop it to completion with immediate done responses.
  task automatic do_order(input logic [1:0] balls);
    req_if.req_valid = 1'b1;
    req_if.req_balls = balls;
    step();
    req_if.req_valid = 1'b0;
    for (int b = 0; b < int'(balls); b++) begin
      wait_go("order_go");
      scoop_done = 1'b1;
      step();
      scoop_done = 1'b0;
    end
    check("order_served", 32'(served), 32'd1);
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{valid: 1'b0, balls: 2'd1, clk_it: 1'b1, exp_ready: 1'b1, exp_reject: 1'b0};
    vecs[1] = '{valid: 1'b1, balls: 2'd0, clk_it: 1'b1, exp_ready: 1'b1, exp_reject: 1'b1};
    vecs[2] = '{valid: 1'b1, balls: 2'd1, clk_it: 1'b0, exp_ready: 1'b1, exp_reject: 1'b0};
    vecs[3] = '{valid: 1'b1, balls: 2'd2, clk_it: 1'b0, exp_ready: 1'b1, exp_reject: 1'b0};
    vecs[4] = '{valid: 1'b1, balls: 2'd3, clk_it: 1'b1, exp_ready: 1'b1, exp_reject: 1'b1};

    // Reset state
    apply_reset();
    check("rst_go", 32'(scoop_go), 32'd0);
    check("rst_served", 32'(served), 32'd0);
    check("rst_reject", 32'(req_if.req_reject), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ready", 32'(req_if.req_ready), 32'd1);
    check("rst_stock", 32'(stock), 32'd20);
    check("rst_level", 32'(queue_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sold_out", 32'(sold_out), 32'd0);

    // Request decode table; illegal counts are clocked to confirm nothing is queued
    for (int i = 0; i < 5; i++) begin
      req_if.req_valid = vecs[i].valid;
      req_if.req_balls = vecs[i].balls;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_if.req_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_reject", i), 32'(req_if.req_reject), 32'(vecs[i].exp_reject));
      if (vecs[i].clk_it) begin
        step();
        check($sformatf("vec%0d_level", i), 32'(queue_level), 32'd0);
        check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      end
      req_if.req_valid = 1'b0;
      #1;
    end

    // Single 1-ball order, done two cycles after go rises
    apply_reset();
    req_if.req_valid = 1'b1;
    req_if.req_balls = 2'd1;
    step();
    req_if.req_valid = 1'b0;
    check("s1_level_push", 32'(queue_level), 32'd1);
    check("s1_go_before_pop", 32'(scoop_go), 32'd0);
    step();
    check("s1_go_pop", 32'(scoop_go), 32'd1);
    check("s1_level_pop", 32'(queue_level), 32'd0);
    step();
    check("s1_go_held", 32'(scoop_go), 32'd1);
    scoop_done = 1'b1;
    step();
    scoop_done = 1'b0;
    check("s1_go_low", 32'(scoop_go), 32'd0);
    check("s1_served", 32'(served), 32'd1);
    check("s1_stock", 32'(stock), 32'd19);
    step();
    check("s1_served_pulse", 32'(served), 32'd0);
    check("s1_idle", 32'(busy), 32'd0);

    // 2-ball then 1-ball back to back
    apply_reset();
    req_if.req_valid = 1'b1;
    req_if.req_balls = 2'd2;
    step();
    req_if.req_balls = 2'd1;
    check("s2_level_a", 32'(queue_level), 32'd1);
    step();
    req_if.req_valid = 1'b0;
    check("s2_level_b", 32'(queue_level), 32'd1);
    check("s2_go1", 32'(scoop_go), 32'd1);
    scoop_done = 1'b1;
    step();
    scoop_done = 1'b0;
    check("s2_gap", 32'(scoop_go), 32'd0);
    check("s2_stock19", 32'(stock), 32'd19);
    check("s2_gap_served", 32'(served), 32'd0);
    step();
    check("s2_go2", 32'(scoop_go), 32'd1);
    scoop_done = 1'b1;
    step();
    scoop_done = 1'b0;
    check("s2_served1", 32'(served), 32'd1);
    check("s2_stock18", 32'(stock), 32'd18);
    check("s2_go_low", 32'(scoop_go), 32'd0);
    step();
    check("s2_idle_go", 32'(scoop_go), 32'd0);
    check("s2_idle_level", 32'(queue_level), 32'd1);
    step();
    check("s2_go3", 32'(scoop_go), 32'd1);
    check("s2_level_c", 32'(queue_level), 32'd0);
    scoop_done = 1'b1;
    step();
    scoop_done = 1'b0;
    check("s2_served2", 32'(served), 32'd1);
    check("s2_stock17", 32'(stock), 32'd17);
    step();
    check("s2_done_busy", 32'(busy), 32'd0);

    // Fill the FIFO with no done responses, then time out
    apply_reset();
    req_if.req_valid = 1'b1;
    req_if.req_balls = 2'd1;
    repeat (5) step();
    check("s3_level_full", 32'(queue_level), 32'd4);
    check("s3_ready_full", 32'(req_if.req_ready), 32'd0);
    check("s3_no_reject_full", 32'(req_if.req_reject), 32'd0);
    repeat (4) step();
    check("s3_go_before_tmo", 32'(scoop_go), 32'd1);
    check("s3_no_fault_yet", 32'(fault), 32'd0);
    step();
    check("s3_fault", 32'(fault), 32'd1);
    check("s3_go_off", 32'(scoop_go), 32'd0);
    repeat (3) step();
    check("s3_fault_sticky", 32'(fault), 32'd1);
    check("s3_go_stays_off", 32'(scoop_go), 32'd0);
    check("s3_level_frozen", 32'(queue_level), 32'd4);
    check("s3_ready_fault", 32'(req_if.req_ready), 32'd0);
    check("s3_no_reject_fault", 32'(req_if.req_reject), 32'd0);
    check("s3_stock", 32'(stock), 32'd20);
    req_if.req_valid = 1'b0;

    // Drain stock to 1, then boundary requests
    apply_reset();
    for (int k = 0; k < 9; k++) do_order(2'd2);
    do_order(2'd1);
    check("s4_stock1", 32'(stock), 32'd1);
    req_if.req_valid = 1'b1;
    req_if.req_balls = 2'd2;
    #1;
    check("s4_reject2", 32'(req_if.req_reject), 32'd1);
    check("s4_ready2", 32'(req_if.req_ready), 32'd1);
    step();
    check("s4_not_queued", 32'(queue_level), 32'd0);
    req_if.req_balls = 2'd1;
    #1;
    check("s4_accept1", 32'(req_if.req_reject), 32'd0);
    step();
    req_if.req_valid = 1'b0;
    check("s4_queued", 32'(queue_level), 32'd1);
    wait_go("s4_go");
    scoop_done = 1'b1;
    step();
    scoop_done = 1'b0;
    check("s4_stock0", 32'(stock), 32'd0);
    check("s4_sold_out", 32'(sold_out), 32'd1);
    check("s4_ready0", 32'(req_if.req_ready), 32'd0);
    req_if.req_valid = 1'b1;
    #1;
    check("s4_reject_empty", 32'(req_if.req_reject), 32'd1);
    req_if.req_valid = 1'b0;
    step();

    // Refill coinciding with done at stock 5
    apply_reset();
    for (int k = 0; k < 7; k++) do_order(2'd2);
    do_order(2'd1);
    check("s5_stock5", 32'(stock), 32'd5);
    req_if.req_valid = 1'b1;
    req_if.req_balls = 2'd1;
    step();
    req_if.req_valid = 1'b0;
    wait_go("s5_go");
    scoop_done = 1'b1;
    refill     = 1'b1;
    step();
    scoop_done = 1'b0;
    refill     = 1'b0;
    check("s5_refill_wins", 32'(stock), 32'd20);
    step();

    // Asynchronous reset in the middle of a scoop
    req_if.req_valid = 1'b1;
    req_if.req_balls = 2'd2;
    step();
    req_if.req_balls = 2'd1;
    step();
    req_if.req_valid = 1'b0;
    check("s6_go1", 32'(scoop_go), 32'd1);
    scoop_done = 1'b1;
    step();
    scoop_done = 1'b0;
    check("s6_stock19", 32'(stock), 32'd19);
    step();
    check("s6_go2", 32'(scoop_go), 32'd1);
    check("s6_level", 32'(queue_level), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_go", 32'(scoop_go), 32'd0);
    check("s6_async_level", 32'(queue_level), 32'd0);
    check("s6_async_stock", 32'(stock), 32'd20);
    check("s6_async_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("s6_after_go", 32'(scoop_go), 32'd0);
    check("s6_after_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
